// File: rtl/div_shift_sub.sv
// div_shift_sub: sequential restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN to compile in two's-complement support (selected per
// operation by sgn). Without it every operation is unsigned and sgn is ignored.
module div_shift_sub #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         sgn,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         busy,
   output logic         done,
   output logic         dz
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam int CW = $clog2(N + 1);

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [N-1:0]  quo_q, rmd_q;
   logic          busy_q, done_q, dz_q;

   // Datapath: partial remainder is one bit wider than the operands so the
   // trial subtraction can never overflow.
   logic [N:0]    rem_q, rem_d;
   logic [N-1:0]  dvd_q, dvd_d;
   logic [N-1:0]  dvs_q;
   logic [N:0]    shifted, diff;

   // Operand magnitudes presented on accept, and final results of the last step
   logic [N-1:0]  a_mag, b_mag;
   logic [N-1:0]  q_fin, r_fin;
   logic          accept;

   // The top remainder bit is always zero between steps (remainder < divisor)
   logic          unused_rem_msb;
   assign unused_rem_msb = rem_q[N];

   assign accept = (state_q == IDLE) && start;

`ifdef DIV_SIGNED_EN
   logic a_neg, b_neg;
   logic negq_q, negr_q;

   function automatic logic [N-1:0] neg(input logic [N-1:0] v);
      return (~v) + {{(N-1){1'b0}}, 1'b1};
   endfunction

   assign a_neg = sgn & dividend[N-1];
   assign b_neg = sgn & divisor[N-1];
   // Most negative value negates to itself, which is its correct unsigned magnitude
   assign a_mag = a_neg ? neg(dividend) : dividend;
   assign b_mag = b_neg ? neg(divisor) : divisor;
   assign q_fin = negq_q ? neg(dvd_d) : dvd_d;
   assign r_fin = negr_q ? neg(rem_d[N-1:0]) : rem_d[N-1:0];

   // Result signs recorded when an operation is accepted
   always_ff @(posedge clk) begin
      if (rst && accept) begin
         negq_q <= a_neg ^ b_neg;
         negr_q <= a_neg;
      end
   end
`else
   logic unused_sgn;
   assign unused_sgn = sgn;
   assign a_mag = dividend;
   assign b_mag = divisor;
   assign q_fin = dvd_d;
   assign r_fin = rem_d[N-1:0];
`endif

   // One restoring step: shift in next dividend bit, trial-subtract, keep or restore
   always_comb begin
      shifted = {rem_q[N-1:0], dvd_q[N-1]};
      diff    = shifted - {1'b0, dvs_q};
      if (!diff[N]) begin
         rem_d = diff;
         dvd_d = {dvd_q[N-2:0], 1'b1};
      end else begin
         rem_d = shifted;
         dvd_d = {dvd_q[N-2:0], 1'b0};
      end
   end

   // Datapath registers: load magnitudes on accept, iterate while running
   always_ff @(posedge clk) begin
      if (rst) begin
         if (accept) begin
            dvd_q <= a_mag;
            dvs_q <= b_mag;
            rem_q <= '0;
         end else if (state_q == RUN) begin
            dvd_q <= dvd_d;
            rem_q <= rem_d;
         end
      end
   end

   // Control FSM with registered outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         quo_q   <= '0;
         rmd_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  busy_q <= 1'b1;
                  if (divisor == '0) begin
                     state_q <= DONE;
                     quo_q   <= '1;
                     rmd_q   <= dividend;
                     dz_q    <= 1'b1;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= RUN;
                     cnt_q   <= CW'(N);
                  end
               end
            end
            RUN: begin
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_q <= DONE;
                  quo_q   <= q_fin;
                  rmd_q   <= r_fin;
                  dz_q    <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign quotient  = quo_q;
   assign remainder = rmd_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign dz        = dz_q;

endmodule

// File: tb/tb_div_shift_sub.sv
// tb_div_shift_sub: randomized and directed checks of div_shift_sub (N=8)
// against a timing/arithmetic reference model kept in the bench.
module tb_div_shift_sub;

   localparam int N = 8;
`ifdef DIV_SIGNED_EN
   localparam bit SIGNED_BUILD = 1'b1;
`else
   localparam bit SIGNED_BUILD = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         sgn = 1'b0;
   logic [N-1:0] dividend = '0;
   logic [N-1:0] divisor = '0;
   logic [N-1:0] quotient, remainder;
   logic         busy, done, dz;

   int total = 0;
   int bad = 0;

   div_shift_sub #(.N(N)) dut (
      .clk(clk), .rst(rst), .start(start), .sgn(sgn),
      .dividend(dividend), .divisor(divisor),
      .quotient(quotient), .remainder(remainder),
      .busy(busy), .done(done), .dz(dz)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad < 40) $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Arithmetic reference: what the result of one division must be
   function automatic void ref_div(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                                   output logic [N-1:0] q, output logic [N-1:0] r, output logic z);
      int sa, sb;
      logic use_s;
      use_s = SIGNED_BUILD && s;
      if (b == 0) begin
         q = '1; r = a; z = 1'b1;
      end else begin
         z = 1'b0;
         if (use_s) begin
            sa = $signed(a);
            sb = $signed(b);
            if (sa == -128 && sb == -1) begin
               q = 8'h80; r = 8'h00;
            end else begin
               q = N'(sa / sb);
               r = N'(sa % sb);
            end
         end else begin
            q = a / b;
            r = a % b;
         end
      end
   endfunction

   // Timing model: edges counted; an accepted op finishes N edges later (0 if divisor is 0)
   int           ecnt = 0;
   bit           active = 0;
   int           a_edge = 0, d_edge = 0;
   logic [N-1:0] m_q = '0, m_r = '0, n_q, n_r;
   logic         m_dz = 1'b0, n_dz;
   bit           chk_en = 0;

   always @(posedge clk) begin
      ecnt++;
      if (!rst) begin
         active = 0;
         m_q = '0; m_r = '0; m_dz = 1'b0;
         chk_en = 1;
      end else begin
         if (start && (!active || ecnt >= d_edge + 2)) begin
            ref_div(dividend, divisor, sgn, n_q, n_r, n_dz);
            active = 1;
            a_edge = ecnt;
            d_edge = ecnt + ((divisor == 0) ? 0 : N);
         end
         if (active && ecnt == d_edge) begin
            m_q = n_q; m_r = n_r; m_dz = n_dz;
         end
      end
   end

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", 32'(busy), 32'(active && ecnt >= a_edge && ecnt <= d_edge));
         chk("done", 32'(done), 32'(active && ecnt == d_edge));
         chk("quotient", 32'(quotient), 32'(m_q));
         chk("remainder", 32'(remainder), 32'(m_r));
         chk("dz", 32'(dz), 32'(m_dz));
      end
   end

   task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
      dividend = a; divisor = b; sgn = s; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Edges after the accepting edge until done is seen
   task automatic wait_done(output int lat);
      lat = 0;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (!done) begin
         bad++;
         total++;
         $display("FAIL done_timeout: got no done within %0d cycles want done", lat);
      end
   endtask

   task automatic op_check(input string nm, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic s, input int lat_w, input logic [N-1:0] q_w,
                           input logic [N-1:0] r_w, input logic dz_w);
      int lat;
      do_op(a, b, s);
      wait_done(lat);
      chk({nm, "_lat"}, 32'(lat), 32'(lat_w));
      chk({nm, "_q"}, 32'(quotient), 32'(q_w));
      chk({nm, "_r"}, 32'(remainder), 32'(r_w));
      chk({nm, "_dz"}, 32'(dz), 32'(dz_w));
      @(negedge clk);
   endtask

   initial begin
      logic [N-1:0] pq, pr, ra, rb;
      logic         pz, rs;
      int           lat, w;

      // Hand-computed values pinning the reference model
      ref_div(8'd100, 8'd7, 1'b0, pq, pr, pz);
      chk("model_100_7", {pq, pr, 7'b0, pz}, {8'd14, 8'd2, 8'd0});
      ref_div(8'd250, 8'd10, 1'b0, pq, pr, pz);
      chk("model_250_10", {pq, pr}, {8'd25, 8'd0});

      // Reset, with a start pulse that must be ignored
      rst = 1'b0;
      @(negedge clk);
      start = 1'b1; dividend = 8'd9; divisor = 8'd3;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_q", 32'(quotient), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      op_check("u100_7", 8'd100, 8'd7, 1'b0, N, 8'd14, 8'd2, 1'b0);
      op_check("u55_0", 8'd55, 8'd0, 1'b0, 0, 8'hFF, 8'd55, 1'b1);
      if (SIGNED_BUILD) begin
         op_check("s_m7_2", 8'hF9, 8'd2, 1'b1, N, 8'hFD, 8'hFF, 1'b0);
         op_check("s_m128_m1", 8'h80, 8'hFF, 1'b1, N, 8'h80, 8'h00, 1'b0);
         op_check("s_m5_0", 8'hFB, 8'h00, 1'b1, 0, 8'hFF, 8'hFB, 1'b1);
         op_check("s_7_m2", 8'd7, 8'hFE, 1'b1, N, 8'hFD, 8'h01, 1'b0);
      end else begin
         op_check("u249_2_sgn", 8'hF9, 8'd2, 1'b1, N, 8'd124, 8'd1, 1'b0);
         op_check("u128_255_sgn", 8'h80, 8'hFF, 1'b1, N, 8'd0, 8'd128, 1'b0);
      end

      // Restart while running is ignored
      do_op(8'd200, 8'd3, 1'b0);
      @(negedge clk);
      do_op(8'd9, 8'd9, 1'b0);
      wait_done(lat);
      chk("restart_q", 32'(quotient), 32'd66);
      chk("restart_r", 32'(remainder), 32'd2);
      @(negedge clk);

      // Reset mid-run discards the operation
      do_op(8'd200, 8'd3, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_q", 32'(quotient), 32'd0);
      chk("midrst_r", 32'(remainder), 32'd0);
      rst = 1'b1;
      op_check("after_rst", 8'd9, 8'd4, 1'b0, N, 8'd2, 8'd1, 1'b0);

      // Back-to-back: next start in the first IDLE cycle after done
      do_op(8'd17, 8'd5, 1'b0);
      wait_done(lat);
      chk("b2b1_q", {quotient, remainder}, {8'd3, 8'd2});
      @(negedge clk);
      op_check("b2b2", 8'd250, 8'd10, 1'b0, N, 8'd25, 8'd0, 1'b0);

      // Randomized operations, checked cycle by cycle by the model
      for (int i = 0; i < 250; i++) begin
         ra = N'($urandom);
         rb = ($urandom_range(0, 9) == 0) ? '0 : N'($urandom);
         if ($urandom_range(0, 3) == 0) rb = N'($urandom_range(1, 3));
         if ($urandom_range(0, 7) == 0) ra = 8'h80;
         rs = 1'($urandom);
         do_op(ra, rb, rs);
         if (rb != 0 && $urandom_range(0, 3) == 0) begin
            w = $urandom_range(0, 5);
            repeat (w) @(negedge clk);
            do_op(N'($urandom), N'($urandom), 1'($urandom));
         end
         wait_done(lat);
         @(negedge clk);
         w = $urandom_range(0, 2);
         repeat (w) @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

endmodule
